// File: rtl/mt_pkg.sv
// Shared types and constants for the multithreaded hazard/forwarding unit.
package mt_pkg;

    localparam int NUM_HARTS_DEF = 4;
    localparam int NUM_REGS_DEF  = 32;

    typedef logic [$clog2(NUM_HARTS_DEF)-1:0] hart_id_t;
    typedef logic [$clog2(NUM_REGS_DEF)-1:0]  reg_addr_t;
    typedef logic [1:0]                       fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_EX  = 2'b11;

endpackage

// File: rtl/mt_sb_bank.sv
// One hart's long-latency busy-register vector, saturating stall counter and
// sticky protocol-error flag.
module mt_sb_bank
    import mt_pkg::*;
#(
    parameter int  NUM_REGS = NUM_REGS_DEF,
    parameter int  CNT_W    = 16,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [RW-1:0]       set_rd,
    input  logic                clr_en,
    input  logic [RW-1:0]       clr_rd,
    input  logic                cnt_inc,
    output logic [NUM_REGS-1:0] busy,
    output logic [CNT_W-1:0]    cnt,
    output logic                err
);

    logic [NUM_REGS-1:0] busy_nx;
    logic                err_evt;

    // Set is applied after clear so a same-cycle set/clear of one register leaves it busy.
    always_comb begin
        busy_nx = busy;
        if (clr_en) busy_nx[clr_rd] = 1'b0;
        if (set_en) busy_nx[set_rd] = 1'b1;
        busy_nx[0] = 1'b0;
    end

    // Register 0 is never busy, so a completion tagged r0 is always reported.
    assign err_evt = (set_en && busy[set_rd]) || (clr_en && !busy[clr_rd]);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_nx;
            if (cnt_inc && (cnt != '1)) cnt <= cnt + CNT_W'(1);
            if (err_evt) err <= 1'b1;
        end
    end

endmodule

// File: rtl/mt_hazard_scoreboard.sv
// Hart-aware EX/ID forwarding selects, ID stall generation and per-hart
// long-latency scoreboard for the multithreaded pipeline.
module mt_hazard_scoreboard
    import mt_pkg::*;
#(
    parameter int  NUM_HARTS = NUM_HARTS_DEF,
    parameter int  NUM_REGS  = NUM_REGS_DEF,
    parameter int  CNT_W     = 16,
    localparam int HW        = $clog2(NUM_HARTS),
    localparam int RW        = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [HW-1:0]              id_hart,
    input  logic [RW-1:0]              id_rs1,
    input  logic [RW-1:0]              id_rs2,
    input  logic [RW-1:0]              id_rd,
    input  logic                       id_uses_rs1,
    input  logic                       id_uses_rs2,
    input  logic                       id_writes_rd,
    input  logic                       ex_valid,
    input  logic                       ex_regwrite,
    input  logic                       ex_long,
    input  logic [HW-1:0]              ex_hart,
    input  logic [RW-1:0]              ex_rs1,
    input  logic [RW-1:0]              ex_rs2,
    input  logic [RW-1:0]              ex_rd,
    input  logic                       mem_valid,
    input  logic                       mem_regwrite,
    input  logic                       mem_is_load,
    input  logic [HW-1:0]              mem_hart,
    input  logic [RW-1:0]              mem_rd,
    input  logic                       wb_valid,
    input  logic                       wb_regwrite,
    input  logic [HW-1:0]              wb_hart,
    input  logic [RW-1:0]              wb_rd,
    input  logic                       done_valid,
    input  logic [HW-1:0]              done_hart,
    input  logic [RW-1:0]              done_rd,
    output logic [1:0]                 fwd_a,
    output logic [1:0]                 fwd_b,
    output logic [1:0]                 fwd_rs1,
    output logic [1:0]                 fwd_rs2,
    output logic                       id_stall,
    output logic [NUM_HARTS*CNT_W-1:0] stall_cnt,
    output logic                       sb_err
);

    function automatic logic hit(input logic v, input logic w,
                                 input logic [RW-1:0] rd, input logic [HW-1:0] sh,
                                 input logic [RW-1:0] src, input logic [HW-1:0] ch);
        return v && w && (rd != '0) && (rd == src) && (sh == ch);
    endfunction

    logic ex_h1, ex_h2, mem_h1, mem_h2, wb_h1, wb_h2;
    logic mem_ha, mem_hb, wb_ha, wb_hb;
    logic [NUM_HARTS-1:0][NUM_REGS-1:0] busy_all;
    logic [NUM_HARTS-1:0]               err_vec;
    logic use1, use2, sb_set;

    assign ex_h1  = hit(ex_valid,  ex_regwrite,  ex_rd,  ex_hart,  id_rs1, id_hart);
    assign ex_h2  = hit(ex_valid,  ex_regwrite,  ex_rd,  ex_hart,  id_rs2, id_hart);
    assign mem_h1 = hit(mem_valid, mem_regwrite, mem_rd, mem_hart, id_rs1, id_hart);
    assign mem_h2 = hit(mem_valid, mem_regwrite, mem_rd, mem_hart, id_rs2, id_hart);
    assign wb_h1  = hit(wb_valid,  wb_regwrite,  wb_rd,  wb_hart,  id_rs1, id_hart);
    assign wb_h2  = hit(wb_valid,  wb_regwrite,  wb_rd,  wb_hart,  id_rs2, id_hart);

    assign mem_ha = hit(mem_valid, mem_regwrite, mem_rd, mem_hart, ex_rs1, ex_hart);
    assign mem_hb = hit(mem_valid, mem_regwrite, mem_rd, mem_hart, ex_rs2, ex_hart);
    assign wb_ha  = hit(wb_valid,  wb_regwrite,  wb_rd,  wb_hart,  ex_rs1, ex_hart);
    assign wb_hb  = hit(wb_valid,  wb_regwrite,  wb_rd,  wb_hart,  ex_rs2, ex_hart);

    assign fwd_a = mem_ha ? FWD_MEM : (wb_ha ? FWD_WB : FWD_RF);
    assign fwd_b = mem_hb ? FWD_MEM : (wb_hb ? FWD_WB : FWD_RF);

    assign use1 = id_valid && id_uses_rs1;
    assign use2 = id_valid && id_uses_rs2;

    // Long-latency EX results and loads in MEM are not yet forwardable; those cases stall instead.
    always_comb begin
        fwd_rs1 = FWD_RF;
        if (use1) begin
            if (ex_h1 && !ex_long)            fwd_rs1 = FWD_EX;
            else if (mem_h1 && !mem_is_load)  fwd_rs1 = FWD_MEM;
            else if (wb_h1)                   fwd_rs1 = FWD_WB;
        end
        fwd_rs2 = FWD_RF;
        if (use2) begin
            if (ex_h2 && !ex_long)            fwd_rs2 = FWD_EX;
            else if (mem_h2 && !mem_is_load)  fwd_rs2 = FWD_MEM;
            else if (wb_h2)                   fwd_rs2 = FWD_WB;
        end
    end

    assign id_stall = id_valid && (
        (use1 && ((ex_h1 && ex_long) || (mem_h1 && mem_is_load) || busy_all[id_hart][id_rs1])) ||
        (use2 && ((ex_h2 && ex_long) || (mem_h2 && mem_is_load) || busy_all[id_hart][id_rs2])) ||
        (id_writes_rd && (id_rd != '0) && busy_all[id_hart][id_rd]));

    assign sb_set = ex_valid && ex_regwrite && ex_long && (ex_rd != '0);

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_bank
        mt_sb_bank #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) u_bank (
            .clk     (clk),
            .reset   (reset),
            .set_en  (sb_set && (ex_hart == HW'(h))),
            .set_rd  (ex_rd),
            .clr_en  (done_valid && (done_hart == HW'(h))),
            .clr_rd  (done_rd),
            .cnt_inc (id_valid && id_stall && (id_hart == HW'(h))),
            .busy    (busy_all[h]),
            .cnt     (stall_cnt[h*CNT_W +: CNT_W]),
            .err     (err_vec[h])
        );
    end

    assign sb_err = |err_vec;

endmodule

// File: tb/tb_mt_hazard_scoreboard.sv
// Directed and randomized bench for mt_hazard_scoreboard with a rule-level reference model.
module tb_mt_hazard_scoreboard;
    import mt_pkg::*;

    localparam int NH   = 4;
    localparam int NR   = 32;
    localparam int CW   = 8;
    localparam int HW   = 2;
    localparam int RW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic clk, reset;
    logic id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd;
    logic [HW-1:0] id_hart, ex_hart, mem_hart, wb_hart, done_hart;
    logic [RW-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, done_rd;
    logic ex_valid, ex_regwrite, ex_long, mem_valid, mem_regwrite, mem_is_load;
    logic wb_valid, wb_regwrite, done_valid;
    logic [1:0] fwd_a, fwd_b, fwd_rs1, fwd_rs2;
    logic id_stall, sb_err;
    logic [NH*CW-1:0] stall_cnt;

    mt_hazard_scoreboard #(.NUM_HARTS(NH), .NUM_REGS(NR), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_hart(id_hart), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_long(ex_long), .ex_hart(ex_hart),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
        .mem_hart(mem_hart), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_hart(wb_hart), .wb_rd(wb_rd),
        .done_valid(done_valid), .done_hart(done_hart), .done_rd(done_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .id_stall(id_stall), .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit busy_m [NH][NR];
    int cnt_m [NH];
    bit err_m;
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic v, input logic w, input logic [RW-1:0] rd,
                               input logic [HW-1:0] sh, input logic [RW-1:0] src,
                               input logic [HW-1:0] ch);
        return v && w && rd != 0 && rd == src && sh == ch;
    endfunction

    function automatic logic [1:0] m_ex_sel(input logic [RW-1:0] src);
        if (hit(mem_valid, mem_regwrite, mem_rd, mem_hart, src, ex_hart)) return FWD_MEM;
        if (hit(wb_valid, wb_regwrite, wb_rd, wb_hart, src, ex_hart)) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic logic [1:0] m_id_sel(input logic [RW-1:0] src, input logic uses);
        if (!(id_valid && uses)) return FWD_RF;
        if (hit(ex_valid, ex_regwrite, ex_rd, ex_hart, src, id_hart) && !ex_long) return FWD_EX;
        if (hit(mem_valid, mem_regwrite, mem_rd, mem_hart, src, id_hart) && !mem_is_load) return FWD_MEM;
        if (hit(wb_valid, wb_regwrite, wb_rd, wb_hart, src, id_hart)) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic bit m_src_stall(input logic [RW-1:0] src);
        return (hit(ex_valid, ex_regwrite, ex_rd, ex_hart, src, id_hart) && ex_long) ||
               (hit(mem_valid, mem_regwrite, mem_rd, mem_hart, src, id_hart) && mem_is_load) ||
               busy_m[id_hart][src];
    endfunction

    function automatic bit m_stall();
        if (!id_valid) return 0;
        return (id_uses_rs1 && m_src_stall(id_rs1)) ||
               (id_uses_rs2 && m_src_stall(id_rs2)) ||
               (id_writes_rd && id_rd != 0 && busy_m[id_hart][id_rd]);
    endfunction

    task automatic idle();
        reset = 0; id_valid = 0; id_hart = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_writes_rd = 0;
        ex_valid = 0; ex_regwrite = 0; ex_long = 0; ex_hart = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_valid = 0; mem_regwrite = 0; mem_is_load = 0; mem_hart = 0; mem_rd = 0;
        wb_valid = 0; wb_regwrite = 0; wb_hart = 0; wb_rd = 0;
        done_valid = 0; done_hart = 0; done_rd = 0;
    endtask

    task automatic comb_chk();
        #1;
        check("fwd_a", 32'(fwd_a), 32'(m_ex_sel(ex_rs1)));
        check("fwd_b", 32'(fwd_b), 32'(m_ex_sel(ex_rs2)));
        check("fwd_rs1", 32'(fwd_rs1), 32'(m_id_sel(id_rs1, id_uses_rs1)));
        check("fwd_rs2", 32'(fwd_rs2), 32'(m_id_sel(id_rs2, id_uses_rs2)));
        check("id_stall", 32'(id_stall), 32'(m_stall()));
    endtask

    task automatic tick();
        bit stl, set;
        stl = m_stall();
        @(posedge clk);
        if (reset) begin
            foreach (busy_m[h, r]) busy_m[h][r] = 0;
            foreach (cnt_m[h]) cnt_m[h] = 0;
            err_m = 0;
        end else begin
            if (stl && cnt_m[id_hart] < CMAX) cnt_m[id_hart]++;
            set = ex_valid && ex_regwrite && ex_long && ex_rd != 0;
            if (set && busy_m[ex_hart][ex_rd]) err_m = 1;
            if (done_valid && !busy_m[done_hart][done_rd]) err_m = 1;
            if (done_valid) busy_m[done_hart][done_rd] = 0;
            if (set) busy_m[ex_hart][ex_rd] = 1;
        end
        #1;
        for (int h = 0; h < NH; h++)
            check($sformatf("stall_cnt%0d", h), 32'(stall_cnt[h*CW +: CW]), 32'(cnt_m[h]));
        check("sb_err", 32'(sb_err), 32'(err_m));
    endtask

    task automatic step();
        comb_chk();
        tick();
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        check("rst_cnt", 32'(stall_cnt), 32'(0));
        check("rst_err", 32'(sb_err), 32'(0));

        // EX operand forwarding priority and hart isolation
        ex_valid = 1; ex_hart = 1; ex_rs1 = 5; ex_rs2 = 5;
        mem_valid = 1; mem_regwrite = 1; mem_hart = 1; mem_rd = 5;
        wb_valid = 1; wb_regwrite = 1; wb_hart = 1; wb_rd = 5;
        comb_chk(); check("tp_fa_mem", 32'(fwd_a), 32'(FWD_MEM)); tick();
        mem_hart = 2;
        comb_chk(); check("tp_fa_wb", 32'(fwd_a), 32'(FWD_WB)); tick();
        wb_hart = 3;
        comb_chk(); check("tp_fa_rf", 32'(fwd_a), 32'(FWD_RF)); tick();

        // ID branch forwarding from EX, then EX long-latency stall
        idle();
        id_valid = 1; id_hart = 0; id_rs1 = 7; id_rs2 = 7; id_uses_rs1 = 1; id_uses_rs2 = 1;
        ex_valid = 1; ex_regwrite = 1; ex_hart = 0; ex_rd = 7;
        mem_valid = 1; mem_regwrite = 1; mem_hart = 0; mem_rd = 7;
        comb_chk(); check("tp_rs1_ex", 32'(fwd_rs1), 32'(FWD_EX));
        check("tp_rs2_ex", 32'(fwd_rs2), 32'(FWD_EX)); tick();
        ex_long = 1;
        comb_chk(); check("tp_long_stall", 32'(id_stall), 32'(1));
        check("tp_rs1_mem", 32'(fwd_rs1), 32'(FWD_MEM)); tick();
        idle(); done_valid = 1; done_hart = 0; done_rd = 7; step();

        // Scoreboard stall on hart 2, released the cycle after completion
        idle(); ex_valid = 1; ex_regwrite = 1; ex_long = 1; ex_hart = 2; ex_rd = 9; step();
        idle(); id_valid = 1; id_hart = 2; id_rs1 = 9; id_uses_rs1 = 1;
        for (int c = 1; c <= 4; c++) begin
            done_valid = (c == 4); done_hart = 2; done_rd = 9;
            comb_chk(); check("tp_sb_stall", 32'(id_stall), 32'(1)); tick();
        end
        done_valid = 0;
        comb_chk(); check("tp_sb_release", 32'(id_stall), 32'(0));
        check("tp_cnt2", 32'(stall_cnt[2*CW +: CW]), 32'(4)); tick();

        // Other hart is not blocked by hart 2's busy register
        idle(); ex_valid = 1; ex_regwrite = 1; ex_long = 1; ex_hart = 2; ex_rd = 9; step();
        idle(); id_valid = 1; id_hart = 3; id_rs1 = 9; id_uses_rs1 = 1;
        comb_chk(); check("tp_h3_nostall", 32'(id_stall), 32'(0)); tick();
        check("tp_cnt3", 32'(stall_cnt[3*CW +: CW]), 32'(0));
        idle(); done_valid = 1; done_hart = 2; done_rd = 9; step();

        // Same-cycle set and clear keeps the entry busy
        idle(); ex_valid = 1; ex_regwrite = 1; ex_long = 1; ex_hart = 1; ex_rd = 3;
        done_valid = 1; done_hart = 1; done_rd = 3; step();
        idle(); id_valid = 1; id_hart = 1; id_rs1 = 3; id_uses_rs1 = 1;
        comb_chk(); check("tp_setwins", 32'(id_stall), 32'(1)); tick();
        idle(); reset = 1; step(); reset = 0;
        check("tp_err_rst", 32'(sb_err), 32'(0));
        idle(); done_valid = 1; done_hart = 0; done_rd = 4; step();
        check("tp_err_set", 32'(sb_err), 32'(1));
        idle(); step(); step();
        check("tp_err_sticky", 32'(sb_err), 32'(1));

        // Register 0 never forwards or becomes busy
        idle(); id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1; id_writes_rd = 1;
        ex_valid = 1; ex_regwrite = 1; ex_long = 1;
        mem_valid = 1; mem_regwrite = 1; wb_valid = 1; wb_regwrite = 1;
        comb_chk(); check("tp_r0_rs1", 32'(fwd_rs1), 32'(FWD_RF));
        check("tp_r0_a", 32'(fwd_a), 32'(FWD_RF)); tick();
        idle(); id_valid = 1; id_uses_rs1 = 1; id_writes_rd = 1;
        comb_chk(); check("tp_r0_nobusy", 32'(id_stall), 32'(0)); tick();

        // Counter saturation on a load-use stall for hart 1
        idle(); id_valid = 1; id_hart = 1; id_rs1 = 6; id_uses_rs1 = 1;
        mem_valid = 1; mem_regwrite = 1; mem_is_load = 1; mem_hart = 1; mem_rd = 6;
        for (int c = 0; c < CMAX + 4; c++) step();
        check("tp_sat", 32'(stall_cnt[CW +: CW]), 32'(CMAX));

        // Reset mid-stall discards pending entries; a late completion is an error
        idle(); ex_valid = 1; ex_regwrite = 1; ex_long = 1; ex_hart = 2; ex_rd = 9; step();
        idle(); id_valid = 1; id_hart = 2; id_rs1 = 9; id_uses_rs1 = 1; step();
        reset = 1; step(); reset = 0;
        check("tp_rst_cnt", 32'(stall_cnt), 32'(0));
        check("tp_rst_err", 32'(sb_err), 32'(0));
        comb_chk(); check("tp_rst_busy", 32'(id_stall), 32'(0)); tick();
        idle(); done_valid = 1; done_hart = 2; done_rd = 9; step();
        check("tp_late_done", 32'(sb_err), 32'(1));

        // Randomized traffic with small register range to provoke collisions
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            id_valid = 1'($urandom); id_hart = HW'($urandom);
            id_rs1 = RW'($urandom_range(0, 7)); id_rs2 = RW'($urandom_range(0, 7));
            id_rd = RW'($urandom_range(0, 7));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); id_writes_rd = 1'($urandom);
            ex_valid = 1'($urandom); ex_regwrite = 1'($urandom); ex_long = ($urandom_range(0, 3) == 0);
            ex_hart = HW'($urandom); ex_rd = RW'($urandom_range(0, 7));
            ex_rs1 = RW'($urandom_range(0, 7)); ex_rs2 = RW'($urandom_range(0, 7));
            mem_valid = 1'($urandom); mem_regwrite = 1'($urandom); mem_is_load = 1'($urandom);
            mem_hart = HW'($urandom); mem_rd = RW'($urandom_range(0, 7));
            wb_valid = 1'($urandom); wb_regwrite = 1'($urandom);
            wb_hart = HW'($urandom); wb_rd = RW'($urandom_range(0, 7));
            done_valid = ($urandom_range(0, 3) == 0); done_hart = HW'($urandom);
            done_rd = RW'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
